// File: rtl/gc_remap_responder_if.sv
// rtl/gc_remap_responder_if.sv - host/GC side signal bundle of the remap-table responder
interface gc_remap_responder_if #(
    parameter int BLK_W = 4,
    parameter int PG_W  = 3
);
    logic             wr_req;
    logic             wr_ack;
    logic [BLK_W-1:0] wr_blk;
    logic [PG_W-1:0]  wr_page;
    logic             inv_valid;
    logic [BLK_W-1:0] inv_blk;
    logic [PG_W-1:0]  inv_page;
    logic [BLK_W-1:0] erase_blk_num;
    logic [BLK_W-1:0] active_blk_num;
    logic             move_flag;
    logic [BLK_W-1:0] invalid_blk_num;
    logic             invalid_flag;
    logic             new_active_request;
    logic             move_done_flag;
    logic             cp_valid;
    logic [BLK_W-1:0] cp_src_blk;
    logic [PG_W-1:0]  cp_src_page;
    logic [BLK_W-1:0] cp_dst_blk;
    logic [PG_W-1:0]  cp_dst_page;

    modport slave (
        input  wr_req, inv_valid, inv_blk, inv_page, erase_blk_num, active_blk_num, move_flag,
        output wr_ack, wr_blk, wr_page, invalid_blk_num, invalid_flag, new_active_request,
               move_done_flag, cp_valid, cp_src_blk, cp_src_page, cp_dst_blk, cp_dst_page
    );

    modport master (
        output wr_req, inv_valid, inv_blk, inv_page, erase_blk_num, active_blk_num, move_flag,
        input  wr_ack, wr_blk, wr_page, invalid_blk_num, invalid_flag, new_active_request,
               move_done_flag, cp_valid, cp_src_blk, cp_src_page, cp_dst_blk, cp_dst_page
    );
endinterface

// File: rtl/gc_remap_responder.sv
// rtl/gc_remap_responder.sv - remap-table end of the GC link: page bitmaps, write pointers, reclaim reports, relocation
module gc_remap_responder #(
    parameter int NUM_BLK       = 16,
    parameter int PAGES_PER_BLK = 8,
    parameter int BLK_W         = 4,
    parameter int INV_THRESH    = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    gc_remap_responder_if.slave  gc
);
    localparam int PG_W  = $clog2(PAGES_PER_BLK);
    localparam int PTR_W = PG_W + 1;
    localparam logic [PTR_W-1:0] FULL     = PTR_W'(PAGES_PER_BLK);
    localparam logic [PTR_W-1:0] THRESH   = PTR_W'(INV_THRESH);
    localparam logic [PG_W-1:0]  PG_LAST  = PG_W'(PAGES_PER_BLK - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLK - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_STALL = 3'd2,
        ST_ERASE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [PAGES_PER_BLK-1:0] valid_q [NUM_BLK];
    logic [PAGES_PER_BLK-1:0] valid_d [NUM_BLK];
    logic [PTR_W-1:0]       wptr_q [NUM_BLK];
    logic [PTR_W-1:0]       wptr_d [NUM_BLK];
    logic [NUM_BLK-1:0]     rep_q, rep_d;
    logic [BLK_W-1:0]       cur_active_q, cur_active_d;
    logic [BLK_W-1:0]       victim_q, victim_d;
    logic [PG_W-1:0]        pidx_q, pidx_d;
    logic [BLK_W-1:0]       scan_ptr_q, scan_ptr_d;
    logic                   invalid_flag_q, invalid_flag_d;
    logic [BLK_W-1:0]       invalid_blk_num_q, invalid_blk_num_d;
    logic                   new_active_request_q, new_active_request_d;
    logic                   move_done_flag_q, move_done_flag_d;

    logic                   wr_ack;
    logic [BLK_W-1:0]       wr_blk;
    logic [PG_W-1:0]        wr_page;
    logic                   cp_valid;
    logic [BLK_W-1:0]       cp_src_blk;
    logic [PG_W-1:0]        cp_src_page;
    logic [BLK_W-1:0]       cp_dst_blk;
    logic [PG_W-1:0]        cp_dst_page;

    logic                   act_full;
    logic [PG_W-1:0]        act_pg;
    logic                   handoff;
    logic                   collide;
    logic                   need_copy;
    logic                   move_ok;
    logic [PTR_W-1:0]       scan_inv;
    logic                   scan_hit;

    function automatic logic [PTR_W-1:0] popcnt(input logic [PAGES_PER_BLK-1:0] v);
        logic [PTR_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PAGES_PER_BLK; i++) begin
            cnt = cnt + PTR_W'(v[i]);
        end
        return cnt;
    endfunction

    assign act_full = (wptr_q[cur_active_q] == FULL);
    assign act_pg   = wptr_q[cur_active_q][PG_W-1:0];

    // A replacement active block must be empty, and never the block being relocated.
    assign handoff = new_active_request_q
                   && (gc.active_blk_num != cur_active_q)
                   && (wptr_q[gc.active_blk_num] == '0)
                   && !((state_q != ST_IDLE) && (gc.active_blk_num == victim_q));

    assign collide   = gc.inv_valid && (gc.inv_blk == victim_q) && (gc.inv_page == pidx_q);
    assign need_copy = valid_q[victim_q][pidx_q] && !collide;

    assign move_ok = gc.move_flag
                   && (gc.erase_blk_num != cur_active_q)
                   && !(handoff && (gc.erase_blk_num == gc.active_blk_num));

    assign scan_inv = wptr_q[scan_ptr_q] - popcnt(valid_q[scan_ptr_q]);
    assign scan_hit = (wptr_q[scan_ptr_q] == FULL)
                    && (scan_inv >= THRESH)
                    && (scan_ptr_q != cur_active_q)
                    && !rep_q[scan_ptr_q]
                    && !((state_q != ST_IDLE) && (scan_ptr_q == victim_q));

    always_comb begin
        state_d              = state_q;
        valid_d              = valid_q;
        wptr_d               = wptr_q;
        rep_d                = rep_q;
        cur_active_d         = cur_active_q;
        victim_d             = victim_q;
        pidx_d               = pidx_q;
        scan_ptr_d           = (scan_ptr_q == BLK_LAST) ? '0 : scan_ptr_q + BLK_W'(1);
        invalid_flag_d       = 1'b0;
        invalid_blk_num_d    = invalid_blk_num_q;
        new_active_request_d = new_active_request_q;
        move_done_flag_d     = 1'b0;
        wr_ack               = 1'b0;
        wr_blk               = '0;
        wr_page              = '0;
        cp_valid             = 1'b0;
        cp_src_blk           = '0;
        cp_src_page          = '0;
        cp_dst_blk           = '0;
        cp_dst_page          = '0;

        // Pages at or above the write pointer were never written, so invalidating them is a no-op.
        if (gc.inv_valid && ({1'b0, gc.inv_page} < wptr_q[gc.inv_blk])) begin
            valid_d[gc.inv_blk][gc.inv_page] = 1'b0;
        end

        if (!RST && (state_q == ST_IDLE) && gc.wr_req && !act_full) begin
            wr_ack                        = 1'b1;
            wr_blk                        = cur_active_q;
            wr_page                       = act_pg;
            valid_d[cur_active_q][act_pg] = 1'b1;
            wptr_d[cur_active_q]          = wptr_q[cur_active_q] + PTR_W'(1);
        end

        if (scan_hit) begin
            invalid_flag_d    = 1'b1;
            invalid_blk_num_d = scan_ptr_q;
            rep_d[scan_ptr_q] = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (move_ok) begin
                    state_d  = ST_MOVE;
                    victim_d = gc.erase_blk_num;
                    pidx_d   = '0;
                end
            end
            ST_MOVE: begin
                if (need_copy && act_full) begin
                    state_d = ST_STALL;
                end else begin
                    if (need_copy) begin
                        cp_valid                      = !RST;
                        cp_src_blk                    = RST ? '0 : victim_q;
                        cp_src_page                   = RST ? '0 : pidx_q;
                        cp_dst_blk                    = RST ? '0 : cur_active_q;
                        cp_dst_page                   = RST ? '0 : act_pg;
                        valid_d[cur_active_q][act_pg] = 1'b1;
                        valid_d[victim_q][pidx_q]     = 1'b0;
                        wptr_d[cur_active_q]          = wptr_q[cur_active_q] + PTR_W'(1);
                    end
                    if (pidx_q == PG_LAST) begin
                        state_d = ST_ERASE;
                    end else begin
                        pidx_d = pidx_q + PG_W'(1);
                    end
                end
            end
            ST_STALL: begin
                if (handoff) begin
                    state_d = ST_MOVE;
                end
            end
            ST_ERASE: begin
                valid_d[victim_q] = '0;
                wptr_d[victim_q]  = '0;
                rep_d[victim_q]   = 1'b0;
                state_d           = ST_DONE;
            end
            ST_DONE: begin
                move_done_flag_d = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The request follows the post-update pointer so it rises on the edge that fills the block.
        if (handoff) begin
            cur_active_d         = gc.active_blk_num;
            new_active_request_d = 1'b0;
        end else begin
            new_active_request_d = (wptr_d[cur_active_q] == FULL);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q              <= ST_IDLE;
            for (int b = 0; b < NUM_BLK; b++) begin
                valid_q[b] <= '0;
                wptr_q[b]  <= '0;
            end
            rep_q                <= '0;
            cur_active_q         <= '0;
            victim_q             <= '0;
            pidx_q               <= '0;
            scan_ptr_q           <= '0;
            invalid_flag_q       <= 1'b0;
            invalid_blk_num_q    <= '0;
            new_active_request_q <= 1'b0;
            move_done_flag_q     <= 1'b0;
        end else begin
            state_q              <= state_d;
            valid_q              <= valid_d;
            wptr_q               <= wptr_d;
            rep_q                <= rep_d;
            cur_active_q         <= cur_active_d;
            victim_q             <= victim_d;
            pidx_q               <= pidx_d;
            scan_ptr_q           <= scan_ptr_d;
            invalid_flag_q       <= invalid_flag_d;
            invalid_blk_num_q    <= invalid_blk_num_d;
            new_active_request_q <= new_active_request_d;
            move_done_flag_q     <= move_done_flag_d;
        end
    end

    // Registered outputs are also masked while RST is high so the bus reads all-zero throughout reset.
    assign gc.wr_ack             = wr_ack;
    assign gc.wr_blk             = wr_blk;
    assign gc.wr_page            = wr_page;
    assign gc.invalid_flag       = invalid_flag_q & ~RST;
    assign gc.invalid_blk_num    = RST ? '0 : invalid_blk_num_q;
    assign gc.new_active_request = new_active_request_q & ~RST;
    assign gc.move_done_flag     = move_done_flag_q & ~RST;
    assign gc.cp_valid           = cp_valid;
    assign gc.cp_src_blk         = cp_src_blk;
    assign gc.cp_src_page        = cp_src_page;
    assign gc.cp_dst_blk         = cp_dst_blk;
    assign gc.cp_dst_page        = cp_dst_page;
endmodule

// File: tb/tb_gc_remap_responder.sv
// tb/tb_gc_remap_responder.sv - scoreboard bench for gc_remap_responder (8 blocks x 4 pages, threshold 4)
module tb_gc_remap_responder;
    localparam int NB = 8;
    localparam int PP = 4;
    localparam int BW = 3;
    localparam int PW = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    gc_remap_responder_if #(.BLK_W(BW), .PG_W(PW)) bus ();

    gc_remap_responder #(
        .NUM_BLK(NB), .PAGES_PER_BLK(PP), .BLK_W(BW), .INV_THRESH(4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .gc  (bus)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int wr_q[$];
    int cp_q[$];
    int inv_q[$];
    int done_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event %0d, expected none (cycle %0d)", name, act, cyc);
    endtask

    function automatic int pack_cp(input int c, input int sb, input int sp, input int db, input int dp);
        return c * 65536 + sb * 4096 + sp * 256 + db * 16 + dp;
    endfunction

    function automatic int outs();
        logic [22:0] v;
        v = {bus.wr_ack, bus.wr_blk, bus.wr_page, bus.invalid_blk_num, bus.invalid_flag,
             bus.new_active_request, bus.move_done_flag, bus.cp_valid, bus.cp_src_blk,
             bus.cp_src_page, bus.cp_dst_blk, bus.cp_dst_page};
        return int'(v);
    endfunction

    // Monitor: every output event pops its expectation from the matching queue.
    always @(negedge CLK) begin
        int got;
        if (bus.wr_ack === 1'b1) begin
            got = int'(bus.wr_blk) * 16 + int'(bus.wr_page);
            if (wr_q.size() == 0) unexpected("wr_ack_extra", got);
            else chk("wr_addr", got, wr_q.pop_front());
        end
        if (bus.cp_valid === 1'b1) begin
            got = pack_cp(cyc, int'(bus.cp_src_blk), int'(bus.cp_src_page),
                          int'(bus.cp_dst_blk), int'(bus.cp_dst_page));
            if (cp_q.size() == 0) unexpected("cp_extra", got);
            else chk("cp_cycle_src_dst", got, cp_q.pop_front());
        end
        if (bus.invalid_flag === 1'b1) begin
            got = int'(bus.invalid_blk_num);
            if (inv_q.size() == 0) unexpected("invalid_flag_extra", got);
            else chk("invalid_blk_num", got, inv_q.pop_front());
        end
        if (bus.move_done_flag === 1'b1) begin
            if (done_q.size() == 0) unexpected("move_done_extra", cyc);
            else chk("move_done_cycle", cyc, done_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int b, input int p);
        bit got;
        got = 1'b0;
        wr_q.push_back(b * 16 + p);
        bus.wr_req = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge CLK);
            got = (bus.wr_ack === 1'b1);
            tick();
        end
        bus.wr_req = 1'b0;
        if (!got) begin
            void'(wr_q.pop_back());
            unexpected("wr_timeout", b * 16 + p);
        end
    endtask

    task automatic do_inv(input int b, input int p);
        bus.inv_valid = 1'b1;
        bus.inv_blk   = BW'(b);
        bus.inv_page  = PW'(p);
        tick();
        bus.inv_valid = 1'b0;
    endtask

    task automatic do_reset(input string name);
        bus.wr_req         = 1'b1;
        bus.inv_valid      = 1'b0;
        bus.move_flag      = 1'b0;
        bus.active_blk_num = '0;
        bus.erase_blk_num  = '0;
        RST = 1'b1;
        tick();
        @(negedge CLK);
        chk(name, outs(), 0);
        tick();
        bus.wr_req = 1'b0;
        RST = 1'b0;
    endtask

    task automatic fill_blk0_then_active1();
        for (int p = 0; p < PP; p++) do_write(0, p);
        bus.active_blk_num = 3'd1;
        do_write(1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int h;
        bus.wr_req = 1'b0;
        bus.inv_valid = 1'b0;
        bus.inv_blk = '0;
        bus.inv_page = '0;
        bus.erase_blk_num = '0;
        bus.active_blk_num = '0;
        bus.move_flag = 1'b0;

        do_reset("reset_outputs");

        // Test 1: fill block 0, then hand off to block 1.
        for (int p = 0; p < PP; p++) do_write(0, p);
        wr_q.push_back(1 * 16 + 0);
        bus.wr_req = 1'b1;
        @(negedge CLK);
        chk("t1_full_no_ack", int'(bus.wr_ack), 0);
        chk("t1_nar_rise", int'(bus.new_active_request), 1);
        tick();
        bus.active_blk_num = 3'd1;
        @(negedge CLK);
        chk("t1_nar_hold", int'(bus.new_active_request), 1);
        chk("t1_handoff_no_ack", int'(bus.wr_ack), 0);
        tick();
        @(negedge CLK);
        chk("t1_nar_drop", int'(bus.new_active_request), 0);
        chk("t1_ack_after_handoff", int'(bus.wr_ack), 1);
        tick();
        bus.wr_req = 1'b0;
        chk("t1_wr_drained", wr_q.size(), 0);

        // Test 2: block 0 fully invalid -> single report.
        for (int p = 0; p < PP; p++) do_inv(0, p);
        inv_q.push_back(0);
        repeat (9) tick();
        chk("t2_report_within_9", inv_q.size(), 0);
        repeat (20) tick();

        // Test 3: move on the active block is ignored; empty move of block 0.
        bus.erase_blk_num = 3'd1;
        bus.move_flag = 1'b1;
        tick();
        bus.move_flag = 1'b0;
        repeat (10) tick();
        bus.erase_blk_num = 3'd0;
        bus.move_flag = 1'b1;
        done_q.push_back(cyc + 7);
        tick();
        bus.move_flag = 1'b0;
        repeat (10) tick();
        chk("t3_done_seen", done_q.size(), 0);
        for (int p = 1; p < PP; p++) do_write(1, p);
        bus.active_blk_num = 3'd0;
        do_write(0, 0);
        chk("t3_drained", wr_q.size() + cp_q.size(), 0);

        // Test 4: partial move, pages 1 and 3 valid.
        do_reset("t4_reset_outputs");
        fill_blk0_then_active1();
        do_inv(0, 0);
        do_inv(0, 2);
        bus.erase_blk_num = 3'd0;
        bus.move_flag = 1'b1;
        c = cyc;
        cp_q.push_back(pack_cp(c + 2, 0, 1, 1, 1));
        cp_q.push_back(pack_cp(c + 4, 0, 3, 1, 2));
        done_q.push_back(c + 7);
        tick();
        bus.move_flag = 1'b0;
        repeat (10) tick();
        chk("t4_drained", cp_q.size() + done_q.size() + inv_q.size(), 0);

        // Test 5: destination fills mid-move -> stall until block 2 is supplied.
        do_reset("t5_reset_outputs");
        fill_blk0_then_active1();
        do_write(1, 1);
        do_write(1, 2);
        do_inv(0, 0);
        do_inv(0, 2);
        bus.erase_blk_num = 3'd0;
        bus.move_flag = 1'b1;
        c = cyc;
        cp_q.push_back(pack_cp(c + 2, 0, 1, 1, 3));
        tick();
        bus.move_flag = 1'b0;
        repeat (6) tick();
        @(negedge CLK);
        chk("t5_nar_in_stall", int'(bus.new_active_request), 1);
        chk("t5_no_done_in_stall", done_q.size() + int'(bus.move_done_flag), 0);
        tick();
        bus.active_blk_num = 3'd2;
        h = cyc;
        cp_q.push_back(pack_cp(h + 1, 0, 3, 2, 0));
        done_q.push_back(h + 4);
        tick();
        @(negedge CLK);
        chk("t5_nar_drop", int'(bus.new_active_request), 0);
        repeat (8) tick();
        chk("t5_drained", cp_q.size() + done_q.size(), 0);

        // Test 6: reset in the middle of a move.
        do_reset("t6_reset_outputs");
        fill_blk0_then_active1();
        bus.erase_blk_num = 3'd0;
        bus.move_flag = 1'b1;
        c = cyc;
        cp_q.push_back(pack_cp(c + 1, 0, 0, 1, 1));
        tick();
        bus.move_flag = 1'b0;
        tick();
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_outputs_in_reset", outs(), 0);
        tick();
        @(negedge CLK);
        chk("t6_outputs_reset_hold", outs(), 0);
        tick();
        RST = 1'b0;
        bus.active_blk_num = 3'd0;
        repeat (12) tick();
        do_write(0, 0);

        chk("end_wr_q", wr_q.size(), 0);
        chk("end_cp_q", cp_q.size(), 0);
        chk("end_inv_q", inv_q.size(), 0);
        chk("end_done_q", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gc_remap_responder.md
Name: gc_remap_responder

Overview:
- Remapping-table-side end of garbage_collection_if. Answers the gc modport: owns per-block page-valid bitmaps and write pointers, and reports reclaimable blocks (invalid_blk_num/invalid_flag).
- Requests new active blocks (new_active_request) and executes valid-page relocation on move_flag, finishing with move_done_flag.
- Sits between the host write/invalidate path and the GC controller.

Parameters:
- NUM_BLK, 16, number of physical blocks.
- PAGES_PER_BLK, 8, pages per block (power of 2).
- BLK_W, 4, block index width; must equal the width of block_t from NVM_pkg.
- INV_THRESH, 8, invalid-page count at or above which a full block is reported (1..PAGES_PER_BLK).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- wr_req  in  1  host page-write request.
- wr_ack  out  1  write accepted this cycle.
- wr_blk  out  BLK_W  block assigned to the accepted write.
- wr_page  out  log2(PAGES_PER_BLK)  page assigned to the accepted write.
- inv_valid  in  1  invalidate one page, no handshake.
- inv_blk  in  BLK_W  invalidate block.
- inv_page  in  log2(PAGES_PER_BLK)  invalidate page.
- erase_blk_num  in  BLK_W  GC victim block.
- active_blk_num  in  BLK_W  GC-supplied next active block.
- move_flag  in  1  start relocation of erase_blk_num.
- invalid_blk_num  out  BLK_W  reported reclaimable block.
- invalid_flag  out  1  one-cycle report strobe.
- new_active_request  out  1  active block full; level signal.
- move_done_flag  out  1  one-cycle relocation/erase complete.
- cp_valid  out  1  page copy issued this cycle.
- cp_src_blk  out  BLK_W  copy source block.
- cp_src_page  out  log2(PAGES_PER_BLK)  copy source page.
- cp_dst_blk  out  BLK_W  copy destination block.
- cp_dst_page  out  log2(PAGES_PER_BLK)  copy destination page.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset: every output is 0.
  - All valid bitmaps, write pointers (wptr) and reported bits are cleared.
  - cur_active = 0. FSM goes to IDLE.
  - RST mid-move aborts the move with no move_done_flag.
- Per-block state: valid[PAGES_PER_BLK], wptr (0..PAGES_PER_BLK), reported bit.
  - Invalid count = wptr minus popcount(valid).
- Host writes:
  - Accepted only when FSM is IDLE and wptr[cur_active] < PAGES_PER_BLK.
  - On acceptance, wr_ack=1 combinationally with wr_blk=cur_active and wr_page=wptr. The valid bit is set and wptr is incremented at the clock edge.
  - Otherwise wr_ack=0 and the host holds wr_req.
- Invalidate:
  - Accepted every cycle. The addressed valid bit is cleared.
  - Invalidating an already-invalid page, or a page at or above wptr, is ignored.
- Active handoff:
  - When wptr[cur_active]==PAGES_PER_BLK, new_active_request=1, registered.
  - It is held until active_blk_num != cur_active and wptr[active_blk_num]==0. On that cycle, cur_active is loaded from active_blk_num, and the request drops on the next cycle.
- Reporting scanner:
  - scan_ptr advances 1 block per cycle and wraps at NUM_BLK-1.
  - A block is reported when wptr==PAGES_PER_BLK, invalid count ≥ INV_THRESH, the block is not cur_active, and reported==0.
  - Report action: registered invalid_flag=1 for one cycle, invalid_blk_num=block, reported set.
  - Worst-case report latency after the condition becomes true is NUM_BLK+1 cycles.
  - Scanning continues in all FSM states.
- FSM states: IDLE, MOVE, STALL, ERASE, DONE.
  - IDLE to MOVE: move_flag=1 in IDLE. The victim is latched from erase_blk_num and pidx=0. move_flag is ignored outside IDLE, and when erase_blk_num==cur_active.
  - MOVE, one page per cycle: if valid[victim][pidx], the page is copied.
    - cp_valid=1, src=victim/pidx, dst=cur_active/wptr.
    - The dst valid bit is set, the src bit is cleared, and wptr[cur_active] is incremented.
  - MOVE, invalidate collision: if inv_valid targets victim/pidx in the same cycle, the page is skipped (no copy).
  - MOVE to ERASE: after pidx==PAGES_PER_BLK-1.
  - MOVE to STALL: if a copy is needed and cur_active is full, go to STALL with pidx held and no copy. new_active_request rises per the handoff rule. Return to MOVE the cycle after cur_active is reloaded.
  - ERASE: the victim's valid bits, wptr and reported bit are cleared. Go to DONE.
  - DONE: move_done_flag=1 for one cycle, then IDLE.
  - Timing with no stalls: move_flag sampled at edge t gives move_done_flag high in cycle t+PAGES_PER_BLK+2.
- Simultaneous events: a write in the same cycle as move_flag is accepted, with the FSM still in IDLE that cycle. The copy dst uses the post-write wptr.

Test Plan:
- Setup for all tests: NUM_BLK=8, PAGES_PER_BLK=4, INV_THRESH=4.
- Test 1, reset then writes: reset, then 4 wr_req → wr_ack blk0 pages 0..3.
  - 5th request gets wr_ack=0 and new_active_request=1.
  - Drive active_blk_num=1 → request drops next cycle; 5th write acks blk1 page0.
- Test 2, reporting: invalidate blk0 pages 0..3 → within 9 cycles invalid_flag pulses exactly once with invalid_blk_num=0; no repeat thereafter.
- Test 3, empty move: move_flag, erase_blk_num=0, all pages invalid → zero cp_valid; move_done_flag at t+6; blk0 wptr=0.
- Test 4, partial move: blk0 pages 1 and 3 valid, cur_active=1 with wptr=1, move_flag → two copies.
  - Copy 1: 0/1→1/1. Copy 2: 0/3→1/2.
  - move_done_flag at t+6.
- Test 5, stall: blk1 wptr=3, victim blk0 has 2 valid pages → 1 copy, then STALL with new_active_request.
  - Supply active_blk_num=2 three cycles later → remaining copy goes to 2/0.
  - move_done_flag is delayed by the stall length.
- Test 6, reset mid-move: assert RST during MOVE → all outputs 0, no move_done_flag, a following write acks blk0 page0.
